serial_feed_ctrl: RTL
=====================

// Module: serial_feed_ctrl
// PURPOSE
//  Upstream feeder for the serial output stage. Buffers DATA_BIT-wide words in a small FIFO.
//  Each word carries a per-word speed flag (fast/slow).
//  Pops one word at a time and drives it onto o_data with a one-cycle o_start.
//  Generates the bit-rate tick o_tick from a programmable divisor until the serial stage
//  returns i_done_tick. i_abort flushes the FIFO and issues o_stop.
// PARAMETERS
//  DATA_BIT    16  width of each data word; matches the serial stage
//  FIFO_DEPTH  4   FIFO entries; power of 2, >= 2
//  DIV_WIDTH   16  width of the tick divisors
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  i_wr_en      in   1          write request for {i_wr_fast, i_wr_data}
//  i_wr_data    in   DATA_BIT   word to queue
//  i_wr_fast    in   1          1 = use i_div_fast for this word, 0 = use i_div_slow
//  i_div_fast   in   DIV_WIDTH  fast divisor; tick period = div+1 clk
//  i_div_slow   in   DIV_WIDTH  slow divisor; tick period = div+1 clk
//  i_abort      in   1          stop current word and flush FIFO
//  i_done_tick  in   1          word-complete pulse from the serial stage
//  o_start      out  1          1-cycle start pulse to the serial stage
//  o_stop       out  1          1-cycle stop pulse to the serial stage
//  o_data       out  DATA_BIT   current word; stable from o_start until next pop
//  o_tick       out  1          bit-rate tick, 1-cycle pulses
//  o_busy       out  1          1 in S_LOAD or S_ACTIVE
//  o_full       out  1          FIFO holds FIFO_DEPTH entries
//  o_empty      out  1          FIFO holds 0 entries
//  o_overflow   out  1          1-cycle pulse when a write is dropped because FIFO is full
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - All outputs 0 except o_empty=1.
//   - FIFO pointers and count = 0, state = S_IDLE, tick counter = 0.
//   - Reset wins over every other input, including mid-word.
//  FIFO:
//   - Write accepted when i_wr_en & ~o_full; the entry is visible next cycle.
//   - No write-to-pop pass-through: a word written at cycle N is popped at N+1 at the earliest.
//   - Write and pop in the same cycle: count unchanged.
//   - o_full/o_empty are derived from a registered count (0..FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
//   - Write while full: word dropped, o_overflow=1 the next cycle.
//  FSM states:
//   - S_IDLE: if ~o_empty, pop. o_data and cur_fast take the head entry at the next edge.
//     Latch div = cur_fast ? i_div_fast : i_div_slow. Go to S_LOAD.
//   - S_LOAD: o_start=1 for exactly this cycle; tick counter cleared -> S_ACTIVE.
//   - S_ACTIVE: counter runs 0..div. o_tick=1 on the cycle count==div, then the counter returns to 0.
//     With div=0, o_tick=1 every cycle. First tick = div+1 cycles after entering S_ACTIVE.
//     On i_done_tick -> S_IDLE: o_tick forced 0, counter cleared.
//  Latency and divisor rules:
//   - Pop cycle N -> o_start at N+1 -> first o_tick at N+2+div.
//   - Back-to-back words: i_done_tick at T -> S_IDLE at T+1 -> next o_start at T+2 (FIFO non-empty).
//   - Divisor inputs change mid-word: no effect until the next pop (divisor latched).
//  Abort:
//   - i_abort in any state: o_stop=1 the next cycle, FIFO flushed (count=0), state=S_IDLE, counter cleared.
//   - o_data holds its last value.
//  Simultaneous events:
//   - i_abort & i_wr_en: abort wins, write dropped, no o_overflow.
//   - i_abort & i_done_tick: abort wins, o_stop still pulses.
//   - i_done_tick outside S_ACTIVE: ignored.
//  Widths: counter and divisors are DIV_WIDTH, unsigned, no saturation needed (count never exceeds div).
// TESTING
//  1. Reset, write 0xA5A5 with fast=1, div_fast=3.
//     -> o_start 2 cycles after write, o_data=0xA5A5, o_tick every 4 clk until i_done_tick.
//  2. Fill 4 words with no pop possible (hold in S_ACTIVE), then write a 5th.
//     -> o_full=1, o_overflow pulse, 5th word never appears on o_data.
//  3. Queue 3 words alternating fast/slow (div 1/7); return i_done_tick after 16 bits each.
//     -> tick periods 2,8,2 clk; o_start spacing = done+2.
//  4. Change i_div_slow mid-word from 7 to 2.
//     -> current word keeps period 8; next slow word uses period 3.
//  5. i_abort in S_ACTIVE with 2 words queued.
//     -> o_stop 1 cycle, o_empty=1, o_tick stops, no further o_start.
//  6. rst asserted during S_ACTIVE, coincident with i_wr_en.
//     -> all outputs 0, o_empty=1, write discarded.

Source files
------------

// File: rtl/serial_feed_ctrl_if.sv
// Bus bundle between the upstream producer, serial_feed_ctrl and the serial output stage.
interface serial_feed_ctrl_if #(
  parameter int DATA_BIT  = 16,
  parameter int DIV_WIDTH = 16
);
  logic                 i_wr_en;
  logic [DATA_BIT-1:0]  i_wr_data;
  logic                 i_wr_fast;
  logic [DIV_WIDTH-1:0] i_div_fast;
  logic [DIV_WIDTH-1:0] i_div_slow;
  logic                 i_abort;
  logic                 i_done_tick;
  logic                 o_start;
  logic                 o_stop;
  logic [DATA_BIT-1:0]  o_data;
  logic                 o_tick;
  logic                 o_busy;
  logic                 o_full;
  logic                 o_empty;
  logic                 o_overflow;

  // Producer / serial-stage side: drives requests, observes controller outputs
  modport master (
    output i_wr_en, i_wr_data, i_wr_fast, i_div_fast, i_div_slow, i_abort, i_done_tick,
    input  o_start, o_stop, o_data, o_tick, o_busy, o_full, o_empty, o_overflow
  );

  // Controller side
  modport slave (
    input  i_wr_en, i_wr_data, i_wr_fast, i_div_fast, i_div_slow, i_abort, i_done_tick,
    output o_start, o_stop, o_data, o_tick, o_busy, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/serial_feed_ctrl.sv
// Word feeder for the serial output stage: small FIFO of {fast, data} entries, pops one
// word at a time, pulses o_start, then generates bit-rate ticks from the latched divisor
// until the serial stage reports the word complete. Abort flushes everything.
module serial_feed_ctrl #(
  parameter int DATA_BIT   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  serial_feed_ctrl_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BIT:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q;
  logic                 stop_q;
  logic [DATA_BIT-1:0]  data_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  logic              full, empty, pop, wr_ok, cnt_wrap;
  logic [DATA_BIT:0] head;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign pop      = (state_q == S_IDLE) && !empty && !bus.i_abort;
  assign wr_ok    = bus.i_wr_en && !full && !bus.i_abort;
  assign cnt_wrap = (cnt_q == div_q);

  // FIFO storage: written only on accepted writes, contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= {bus.i_wr_fast, bus.i_wr_data};
    end
  end

  // FIFO pointers, occupancy and overflow flag; abort flushes and suppresses overflow
  always_ff @(posedge clk) begin
    if (rst || bus.i_abort) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.i_wr_en && full;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_ok && pop) count_q <= count_q - 1'b1;
    end
  end

  // Current word, latched divisor, tick counter and stop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      stop_q <= 1'b0;
    end else begin
      stop_q <= bus.i_abort;
      if (bus.i_abort) begin
        cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
            if (pop) begin
              data_q <= head[DATA_BIT-1:0];
              div_q  <= head[DATA_BIT] ? bus.i_div_fast : bus.i_div_slow;
            end
          end
          S_LOAD: cnt_q <= '0;
          S_ACTIVE: begin
            if (bus.i_done_tick || cnt_wrap) cnt_q <= '0;
            else                             cnt_q <= cnt_q + 1'b1;
          end
          default: cnt_q <= '0;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (bus.i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (!empty) state_d = S_LOAD;
        S_LOAD:   state_d = S_ACTIVE;
        S_ACTIVE: if (bus.i_done_tick) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs; tick is masked in the cycle the word completes
  always_comb begin
    bus.o_start = (state_q == S_LOAD);
    bus.o_busy  = (state_q == S_LOAD) || (state_q == S_ACTIVE);
    bus.o_tick  = (state_q == S_ACTIVE) && cnt_wrap && !bus.i_done_tick;
  end

  assign bus.o_stop     = stop_q;
  assign bus.o_data     = data_q;
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_overflow = overflow_q;

endmodule
